// File: rtl/rv32_dmem_ctrl_pkg.sv
// Purpose: request types shared by the memory stage and the data-memory controller.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package rv32_dmem_ctrl_pkg;

  typedef enum logic [3:0] {
    MEM_NOP,
    MEM_LB,
    MEM_LH,
    MEM_LW,
    MEM_LBU,
    MEM_LHU,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_op_t;

  typedef struct packed {
    logic [31:0] addr;
    mem_op_t     op;
    logic [31:0] data;
  } memory_request_t;

endpackage

// File: rtl/rv32_dmem_ctrl.sv
// Purpose: data-memory controller; one req/gnt/rvalid bus transaction per memory-stage request.
// Latency: request_done 3 cycles after the request with immediate gnt and rvalid one cycle later; 1 cycle when misaligned.
// Backpressure: stalls the pipeline (request_done low) until grant and response arrive or the wait timer expires.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   data_request                addr/op/data from the memory stage, held stable while stalled
//   request_done                one-cycle completion pulse; load_data/misaligned/bus_error valid with it
//   bus_req/we/addr/be/wdata    bus command, held stable until bus_gnt
//   bus_gnt/rvalid/rdata        bus acceptance and response
module rv32_dmem_ctrl
  import rv32_dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            resetn,
  input  memory_request_t data_request,
  output logic            request_done,
  output logic [31:0]     load_data,
  output logic            misaligned,
  output logic            bus_error,
  output logic            bus_req,
  output logic            bus_we,
  output logic [31:0]     bus_addr,
  output logic [3:0]      bus_be,
  output logic [31:0]     bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [31:0]     bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, GNT_WAIT, RSP_WAIT, DONE} state_t;

  state_t        state;
  mem_op_t       op_q;
  logic [1:0]    off_q;
  logic [CW-1:0] wait_cnt;
  logic          outstanding;

  logic [CW-1:0] cnt_inc;
  logic          timed_out;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;
  logic          req_we;
  logic          req_misaligned;
  logic [31:0]   rd_shift;
  logic [31:0]   ext_data;

  // Wait budget covers GNT_WAIT and RSP_WAIT together; the counter is not
  // cleared at grant.
  assign cnt_inc   = wait_cnt + CW'(1);
  assign timed_out = (cnt_inc >= TMO);

  // Decode of the incoming request; only consumed in IDLE.
  always_comb begin
    req_be         = 4'b0000;
    req_wdata      = '0;
    req_we         = 1'b0;
    req_misaligned = 1'b0;
    case (data_request.op)
      MEM_LB, MEM_LBU: req_be = 4'b0001 << data_request.addr[1:0];
      MEM_LH, MEM_LHU: begin
        req_be         = 4'b0011 << data_request.addr[1:0];
        req_misaligned = data_request.addr[0];
      end
      MEM_LW: begin
        req_be         = 4'b1111;
        req_misaligned = |data_request.addr[1:0];
      end
      MEM_SB: begin
        req_be    = 4'b0001 << data_request.addr[1:0];
        req_we    = 1'b1;
        req_wdata = {4{data_request.data[7:0]}};
      end
      MEM_SH: begin
        req_be         = 4'b0011 << data_request.addr[1:0];
        req_we         = 1'b1;
        req_wdata      = {2{data_request.data[15:0]}};
        req_misaligned = data_request.addr[0];
      end
      MEM_SW: begin
        req_be         = 4'b1111;
        req_we         = 1'b1;
        req_wdata      = data_request.data;
        req_misaligned = |data_request.addr[1:0];
      end
      default: ;
    endcase
  end

  // Lane select and extension from the latched op/offset; stores yield 0.
  always_comb begin
    rd_shift = bus_rdata >> {off_q, 3'b000};
    case (op_q)
      MEM_LB:  ext_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      MEM_LBU: ext_data = {24'h0, rd_shift[7:0]};
      MEM_LH:  ext_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      MEM_LHU: ext_data = {16'h0, rd_shift[15:0]};
      MEM_LW:  ext_data = bus_rdata;
      default: ext_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      op_q         <= MEM_NOP;
      off_q        <= 2'b00;
      wait_cnt     <= '0;
      outstanding  <= 1'b0;
      request_done <= 1'b0;
      load_data    <= '0;
      misaligned   <= 1'b0;
      bus_error    <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
    end else begin
      // A grant always leaves a response owed, even if the request is being
      // aborted in the same cycle; any rvalid settles the owed response, so a
      // late one for an aborted request is swallowed here.
      if (state == GNT_WAIT && bus_gnt)
        outstanding <= 1'b1;
      else if (bus_rvalid)
        outstanding <= 1'b0;

      case (state)
        IDLE: begin
          if (data_request.op != MEM_NOP) begin
            if (req_misaligned) begin
              misaligned   <= 1'b1;
              request_done <= 1'b1;
              state        <= DONE;
            end else begin
              op_q      <= data_request.op;
              off_q     <= data_request.addr[1:0];
              bus_req   <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= {data_request.addr[31:2], 2'b00};
              bus_be    <= req_be;
              bus_wdata <= req_wdata;
              wait_cnt  <= '0;
              state     <= GNT_WAIT;
            end
          end
        end
        GNT_WAIT: begin
          wait_cnt <= cnt_inc;
          if (timed_out) begin
            bus_req      <= 1'b0;
            bus_error    <= 1'b1;
            load_data    <= '0;
            request_done <= 1'b1;
            state        <= DONE;
          end else if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= RSP_WAIT;
          end
        end
        RSP_WAIT: begin
          wait_cnt <= cnt_inc;
          if (bus_rvalid && outstanding) begin
            load_data    <= ext_data;
            request_done <= 1'b1;
            state        <= DONE;
          end else if (timed_out) begin
            bus_error    <= 1'b1;
            load_data    <= '0;
            request_done <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          request_done <= 1'b0;
          misaligned   <= 1'b0;
          bus_error    <= 1'b0;
          load_data    <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_dmem_ctrl.sv
// Purpose: scoreboard bench for rv32_dmem_ctrl with a configurable bus responder.
// Latency: n/a.
// Backpressure: responder grants after gnt_delay request cycles, answers one cycle after grant.
module tb_rv32_dmem_ctrl;
  import rv32_dmem_ctrl_pkg::*;

  logic            clk = 1'b0;
  logic            resetn;
  memory_request_t data_request;
  logic            request_done;
  logic [31:0]     load_data;
  logic            misaligned;
  logic            bus_error;
  logic            bus_req;
  logic            bus_we;
  logic [31:0]     bus_addr;
  logic [3:0]      bus_be;
  logic [31:0]     bus_wdata;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [31:0]     bus_rdata;

  always #5 clk = ~clk;

  rv32_dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_request (data_request),
    .request_done (request_done),
    .load_data    (load_data),
    .misaligned   (misaligned),
    .bus_error    (bus_error),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata)
  );

  typedef struct {
    logic [31:0] load;
    logic        mis;
    logic        berr;
    logic        chk_load;
    int          done_cyc;
  } rsp_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  rsp_exp_t    rsp_q[$];
  bus_exp_t    bus_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_seen = 0;
  int          gnt_delay = 0;
  bit          gnt_en = 1'b1;
  bit          stray = 1'b0;
  logic [31:0] rdata_cfg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus responder: grant after gnt_delay request cycles, respond next cycle.
  initial begin : responder
    int req_cnt;
    bit pending;
    req_cnt    = 0;
    pending    = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      if (pending || stray) begin
        bus_rvalid = 1'b1;
        bus_rdata  = pending ? rdata_cfg : 32'hBAD0_BAD0;
        pending    = 1'b0;
        stray      = 1'b0;
      end
      if (bus_req && gnt_en) begin
        if (req_cnt == gnt_delay) begin
          bus_gnt = 1'b1;
          pending = 1'b1;
          req_cnt = 0;
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin : rsp_mon
    rsp_exp_t e;
    if (resetn && request_done) begin
      done_seen++;
      if (rsp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("misaligned", misaligned, e.mis);
        chk("bus_error", bus_error, e.berr);
        if (e.chk_load) chk("load_data", load_data, e.load);
      end
    end
  end

  // Bus command monitor, sampled at the accepting cycle.
  always @(negedge clk) begin : bus_mon
    bus_exp_t b;
    if (resetn && bus_req && bus_gnt) begin
      if (bus_q.size() == 0) begin
        chk("unexpected_bus_xfer", 32'd1, 32'd0);
      end else begin
        b = bus_q.pop_front();
        chk("bus_we", bus_we, b.we);
        chk("bus_addr", bus_addr, b.addr);
        chk("bus_be", bus_be, b.be);
        if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
      end
    end
  end

  task automatic issue(input mem_op_t op, input logic [31:0] addr, input logic [31:0] data,
                       input int lat, input logic [31:0] exp_load, input logic mis,
                       input logic berr, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    rsp_exp_t r;
    bus_exp_t b;
    bit       done;
    @(posedge clk);
    #1;
    data_request = '{addr: addr, op: op, data: data};
    r = '{load: exp_load, mis: mis, berr: berr, chk_load: !mis, done_cyc: cyc + lat};
    rsp_q.push_back(r);
    if (!mis && !berr) begin
      b.we    = (op == MEM_SB || op == MEM_SH || op == MEM_SW);
      b.addr  = {addr[31:2], 2'b00};
      b.be    = exp_be;
      b.wdata = exp_wdata;
      bus_q.push_back(b);
    end
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = request_done;
    end
    if (!done) chk("done_wait_expired", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    data_request = '{addr: 32'h0, op: MEM_NOP, data: 32'h0};
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    resetn       = 1'b0;
    data_request = '{addr: 32'h0, op: MEM_NOP, data: 32'h0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_request_done", request_done, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_misaligned", misaligned, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    resetn = 1'b1;

    rdata_cfg = 32'hDEAD_BEEF;
    issue(MEM_LW,  32'h100, 32'h0, 3, 32'hDEAD_BEEF, 0, 0, 4'b1111, 32'h0);
    rdata_cfg = 32'h8012_3456;
    issue(MEM_LB,  32'h103, 32'h0, 3, 32'hFFFF_FF80, 0, 0, 4'b1000, 32'h0);
    issue(MEM_LBU, 32'h103, 32'h0, 3, 32'h0000_0080, 0, 0, 4'b1000, 32'h0);
    rdata_cfg = 32'hF00D_1234;
    issue(MEM_LH,  32'h102, 32'h0, 3, 32'hFFFF_F00D, 0, 0, 4'b1100, 32'h0);
    rdata_cfg = 32'hF00D_8234;
    issue(MEM_LHU, 32'h100, 32'h0, 3, 32'h0000_8234, 0, 0, 4'b0011, 32'h0);
    rdata_cfg = 32'hFFFF_FFFF;
    issue(MEM_SH,  32'h22, 32'h1234_ABCD, 3, 32'h0, 0, 0, 4'b1100, 32'hABCD_ABCD);
    issue(MEM_SB,  32'h41, 32'h0000_00A5, 3, 32'h0, 0, 0, 4'b0010, 32'hA5A5_A5A5);
    issue(MEM_LW,  32'h102, 32'h0, 1, 32'h0, 1, 0, 4'b0000, 32'h0);
    issue(MEM_LH,  32'h101, 32'h0, 1, 32'h0, 1, 0, 4'b0000, 32'h0);

    // Grant withheld: four wait cycles then abort.
    gnt_en = 1'b0;
    issue(MEM_LW,  32'h200, 32'h0, 5, 32'h0, 0, 1, 4'b1111, 32'h0);
    gnt_en = 1'b1;

    // Stray response with nothing outstanding must not complete anything.
    @(posedge clk);
    #1;
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_no_done", request_done, 0);
    end
    rdata_cfg = 32'h0000_7F00;
    issue(MEM_LB,  32'h101, 32'h0, 3, 32'h0000_007F, 0, 0, 4'b0010, 32'h0);

    // First store completes with a delayed grant; second is killed by reset.
    gnt_delay = 2;
    rdata_cfg = 32'h0;
    issue(MEM_SW,  32'h40, 32'h1122_3344, 5, 32'h0, 0, 0, 4'b1111, 32'h1122_3344);
    @(posedge clk);
    #1;
    data_request = '{addr: 32'h40, op: MEM_SW, data: 32'h5566_7788};
    @(posedge clk);
    #1;
    chk("sw2_bus_req", bus_req, 1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_bus_req", bus_req, 0);
    chk("rst_mid_request_done", request_done, 0);
    chk("rst_mid_bus_be", bus_be, 0);
    chk("rst_mid_bus_addr", bus_addr, 0);
    data_request = '{addr: 32'h0, op: MEM_NOP, data: 32'h0};
    resetn = 1'b1;

    gnt_delay = 0;
    rdata_cfg = 32'hCAFE_F00D;
    issue(MEM_LW,  32'h40, 32'h0, 3, 32'hCAFE_F00D, 0, 0, 4'b1111, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("bus_queue_drained", bus_q.size(), 0);
    chk("done_count", done_seen, 13);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
